// File: rtl/parking_keypad.sv
// parking_keypad: two-digit keypad feeding a gate controller; lockout after repeated rejects enabled by PARKING_KEYPAD_LOCKOUT_EN
module parking_keypad #(
  parameter int TIMEOUT_CYCLES = 50,
  parameter int MAX_TRIES = 3,
  parameter int LOCK_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance,
  input  logic       key_valid,
  input  logic [1:0] key_code,
  input  logic       key_clear,
  input  logic       gate_green,
  input  logic       gate_red,
  output logic [1:0] password_1,
  output logic [1:0] password_2,
  output logic       pw_valid,
  output logic [1:0] digit_count,
  output logic       locked
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PARKING_KEYPAD_LOCKOUT_EN
  typedef enum logic [2:0] {IDLE, DIGIT1, DIGIT2, PRESENT, DONE, LOCKOUT} state_t;
`else
  typedef enum logic [2:0] {IDLE, DIGIT1, DIGIT2, PRESENT, DONE} state_t;
`endif
  state_t r_state, w_nxt, w_red;
  logic [TW-1:0] r_tmo;
  logic [1:0] w_p1, w_p2;
`ifdef PARKING_KEYPAD_LOCKOUT_EN
  localparam int CW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  logic [CW-1:0] r_tries;
  logic [LW-1:0] r_lk;
  assign w_red = (r_tries == CW'(MAX_TRIES - 1)) ? LOCKOUT : DIGIT1;
`else
  assign w_red = DIGIT1;
  assign locked = 1'b0;
`endif
  // next state and next password digits; sensor loss always wins, then clear, then key, then timeout
  always_comb begin
    w_nxt = r_state;
    w_p1 = password_1;
    w_p2 = password_2;
    case (r_state)
      IDLE: w_nxt = sensor_entrance ? DIGIT1 : IDLE;
      DIGIT1, DIGIT2: begin
        if (!sensor_entrance) w_nxt = IDLE;
        else if (key_clear) w_nxt = DIGIT1;
        else if (key_valid) begin
          w_nxt = (r_state == DIGIT1) ? DIGIT2 : PRESENT;
          w_p1 = (r_state == DIGIT1) ? key_code : password_1;
          w_p2 = (r_state == DIGIT2) ? key_code : password_2;
        end else if (r_tmo == '0) w_nxt = IDLE;
      end
      PRESENT: w_nxt = !sensor_entrance ? IDLE : gate_green ? DONE : gate_red ? w_red : PRESENT;
      DONE: w_nxt = sensor_entrance ? DONE : IDLE;
`ifdef PARKING_KEYPAD_LOCKOUT_EN
      LOCKOUT: w_nxt = (r_lk == '0) ? IDLE : LOCKOUT;
`endif
      default: w_nxt = IDLE;
    endcase
  end
  // state, inactivity timer and registered outputs decoded from the next state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_tmo <= '0;
      password_1 <= '0;
      password_2 <= '0;
      pw_valid <= 1'b0;
      digit_count <= '0;
    end else begin
      r_state <= w_nxt;
      r_tmo <= (w_nxt != r_state || key_clear) ? TW'(TIMEOUT_CYCLES - 1) : r_tmo - TW'(1);
      password_1 <= w_p1;
      password_2 <= w_p2;
      pw_valid <= w_nxt == PRESENT;
      digit_count <= (w_nxt == DIGIT2) ? 2'd1 : (w_nxt == PRESENT) ? 2'd2 : 2'd0;
    end
`ifdef PARKING_KEYPAD_LOCKOUT_EN
  // rejected-attempt counter and lockout duration timer
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_tries <= '0;
      r_lk <= '0;
      locked <= 1'b0;
    end else begin
      r_tries <= (w_nxt == IDLE || w_nxt == DONE) ? '0 : (r_state == PRESENT && w_nxt != PRESENT) ? r_tries + CW'(1) : r_tries;
      r_lk <= (r_state != LOCKOUT) ? LW'(LOCK_CYCLES - 1) : r_lk - LW'(1);
      locked <= w_nxt == LOCKOUT;
    end
`endif
endmodule

// File: doc/parking_keypad.md
PARKING_KEYPAD -- requirements
Module: parking_keypad

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50: idle cycles allowed between key presses before the session aborts.
REQ-002 Parameter MAX_TRIES, default 3: rejected attempts before lockout.
REQ-003 Parameter LOCK_CYCLES, default 100: lockout duration in clk cycles.
REQ-004 Signal clk  input  1: single rising-edge clock for all state.
REQ-005 Signal reset_n  input  1: asynchronous, active-low reset.
REQ-006 Signal sensor_entrance  input  1: car present at entrance; enables a session.
REQ-007 Signal key_valid  input  1: one-cycle strobe, key_code valid.
REQ-008 Signal key_code  input  2: digit value of the pressed key.
REQ-009 Signal key_clear  input  1: one-cycle strobe, discard the entered digits.
REQ-010 Signal gate_green  input  1: gate controller accepted the password (GREEN_LED).
REQ-011 Signal gate_red  input  1: gate controller rejected the password (RED_LED).
REQ-012 Signal password_1  output  2: first digit, registered, to the gate controller.
REQ-013 Signal password_2  output  2: second digit, registered, to the gate controller.
REQ-014 Signal pw_valid  output  1: password_1/password_2 are stable and presented.
REQ-015 Signal digit_count  output  2: digits entered this attempt (0, 1 or 2).
REQ-016 Signal locked  output  1: lockout is active and keys are ignored.

Function
REQ-017 The FSM SHALL have the states IDLE, DIGIT1, DIGIT2, PRESENT, DONE and LOCKOUT, and all outputs SHALL be registered.
REQ-018 IDLE: sensor_entrance=1 SHALL move the FSM to DIGIT1 on the next edge with digit_count=0; keys SHALL be ignored.
REQ-019 DIGIT1: key_valid SHALL latch key_code into password_1, set digit_count=1 and move the FSM to DIGIT2.
REQ-020 DIGIT2: key_valid SHALL latch key_code into password_2, set digit_count=2 and move the FSM to PRESENT; key_clear SHALL return the FSM to DIGIT1 with digit_count=0.
REQ-021 PRESENT: pw_valid SHALL be 1 with password_1 and password_2 held constant; key_valid and key_clear SHALL be ignored.
REQ-022 In PRESENT, gate_green SHALL deassert pw_valid on the next edge and move the FSM to DONE; DONE SHALL return to IDLE once sensor_entrance=0.
REQ-023 In PRESENT, gate_red SHALL deassert pw_valid, increment the try counter and move the FSM to DIGIT1 (or to LOCKOUT per REQ-030).
REQ-024 If gate_green and gate_red are both 1 in the same cycle, gate_green SHALL take priority.
REQ-025 The timeout counter SHALL reload on entry to DIGIT1/DIGIT2 and on every key_valid; after TIMEOUT_CYCLES cycles without a key in DIGIT1/DIGIT2 the FSM SHALL go to IDLE with digit_count=0 and the try counter cleared.
REQ-026 sensor_entrance=0 in DIGIT1, DIGIT2 or PRESENT SHALL abort to IDLE on the next edge, clear pw_valid and clear the try counter.
REQ-027 key_valid and key_clear asserted in the same cycle SHALL act as key_clear only.
REQ-028 password_1 and password_2 SHALL keep their last values outside PRESENT; only pw_valid qualifies them.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, password_1=0, password_2=0, pw_valid=0, digit_count=0, locked=0, and clear the try, timeout and lockout counters, including mid-session.

Configuration
REQ-030 With PARKING_KEYPAD_LOCKOUT_EN defined, a gate_red that brings the try counter to MAX_TRIES SHALL enter LOCKOUT with locked=1; LOCKOUT SHALL ignore all inputs except reset_n for LOCK_CYCLES cycles, then return to IDLE with locked=0 and the try counter cleared.
REQ-031 Without PARKING_KEYPAD_LOCKOUT_EN, no LOCKOUT state or try/lock counters SHALL exist, locked SHALL be tied 0, and every gate_red SHALL return the FSM to DIGIT1.

Verification
REQ-032 Reset, then sensor_entrance=1, keys 1 then 2, then gate_green -> password_1=1, password_2=2, pw_valid=1 until the cycle after gate_green; state is DONE, then IDLE after sensor_entrance=0.
REQ-033 Key 3, then key_clear, then keys 1,2 -> digit_count 1,0,1,2; password_1=1, password_2=2 presented.
REQ-034 Key 1, then no key for 50 cycles -> IDLE with digit_count=0 and pw_valid never asserted.
REQ-035 With LOCKOUT_EN: three attempts each answered by gate_red -> locked=1 for exactly 100 cycles, keys ignored, then IDLE; without LOCKOUT_EN the 3rd gate_red returns to DIGIT1.
REQ-036 gate_green and gate_red together while in PRESENT -> DONE; reset_n=0 asserted in DIGIT2 -> all outputs 0 asynchronously.
